// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared processor constants for the register bank
//
// Purpose: data width, register count, write-enable bit indices and
//          read-select codes, plus the read-code decoder used by reg_bank.
// Ports:   none (package).

package reg_bank_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 20;

  // WrEn bit indices; bits 0..13 are the general registers R1..R14.
  localparam int WE_R1   = 0;
  localparam int WE_R14  = 13;
  localparam int WE_TOTR = 14;
  localparam int WE_TR   = 15;
  localparam int WE_PC   = 16;
  localparam int WE_AR   = 17;
  localparam int WE_MDDR = 18;
  localparam int WE_IR   = 19;

  // RdSel codes.
  localparam logic [4:0] RD_R1   = 5'd1;
  localparam logic [4:0] RD_R14  = 5'd14;
  localparam logic [4:0] RD_TOTR = 5'd15;
  localparam logic [4:0] RD_TR   = 5'd16;
  localparam logic [4:0] RD_PC   = 5'd17;
  localparam logic [4:0] RD_AR   = 5'd18;
  localparam logic [4:0] RD_MDDR = 5'd21;
  localparam logic [4:0] RD_IR   = 5'd22;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } rd_sel_t;

  // Maps a read code onto the WrEn bit index of the same register.
  // Codes 1..18 are contiguous with WrEn bits 0..17; MDDR and IR sit at
  // 21/22 and fold back onto bits 18/19. Anything else reads as zero.
  function automatic rd_sel_t rd_decode(input logic [4:0] code);
    rd_sel_t r;
    r.valid = 1'b0;
    r.idx   = 5'd0;
    if (code >= RD_R1 && code <= RD_AR) begin
      r.valid = 1'b1;
      r.idx   = code - 5'd1;
    end else if (code == RD_MDDR) begin
      r.valid = 1'b1;
      r.idx   = 5'(WE_MDDR);
    end else if (code == RD_IR) begin
      r.valid = 1'b1;
      r.idx   = 5'(WE_IR);
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_bank_reg16_inc.sv
// rtl/reg_bank_reg16_inc.sv - 16-bit register cell with load and increment
//
// Purpose: holds one register value; a load takes priority over an
//          increment in the same cycle, and the increment wraps at the
//          data width with no carry out.
// Ports:   clk_i  - clock, rising edge
//          rst_ni - asynchronous active-low clear
//          ld_i   - load d_i this cycle
//          d_i    - load data
//          inc_i  - add one this cycle (ignored when ld_i is set)
//          q_o    - current register value

module reg16_inc
  import reg_bank_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              inc_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = d_i;
    end else if (inc_i) begin
      q_d = q_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - processor register bank with PC/AR increment and MDDR load
//
// Purpose: twenty 16-bit registers written from C_bus under WrEn, one read
//          port onto B_bus selected by RdSel, direct outputs for the special
//          registers, and a one-cycle Conflict pulse when a memory return and
//          a bus write hit MDDR together.
// Ports:   Clock, Reset_n          - clock and async active-low reset
//          WrEn[19:0], C_bus       - write enables and write data
//          RdSel[4:0], B_bus       - read select and read data
//          PC_inc, AR_inc          - increment requests
//          Mem_valid, Mem_data     - memory return into MDDR
//          PC_out .. TR_out        - direct register values
//          Conflict                - MDDR load collision, registered pulse

module reg_bank
  import reg_bank_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [NUM_REGS-1:0] WrEn,
  input  logic [DATA_W-1:0]   C_bus,
  input  logic [4:0]          RdSel,
  output logic [DATA_W-1:0]   B_bus,
  input  logic                PC_inc,
  input  logic                AR_inc,
  input  logic                Mem_valid,
  input  logic [DATA_W-1:0]   Mem_data,
  output logic [DATA_W-1:0]   PC_out,
  output logic [DATA_W-1:0]   AR_out,
  output logic [DATA_W-1:0]   MDDR_out,
  output logic [DATA_W-1:0]   IR_out,
  output logic [DATA_W-1:0]   TR_out,
  output logic                Conflict
);

  logic [DATA_W-1:0] reg_q   [NUM_REGS];
  logic              ld      [NUM_REGS];
  logic [DATA_W-1:0] ld_data [NUM_REGS];
  logic              inc     [NUM_REGS];

  logic    conflict_q;
  logic    conflict_d;
  rd_sel_t rd;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      ld[i]      = WrEn[i];
      ld_data[i] = C_bus;
      inc[i]     = 1'b0;
    end
    inc[WE_PC] = PC_inc;
    inc[WE_AR] = AR_inc;
    // Memory return wins over a bus write to MDDR.
    ld[WE_MDDR]      = WrEn[WE_MDDR] | Mem_valid;
    ld_data[WE_MDDR] = Mem_valid ? Mem_data : C_bus;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    reg16_inc u_reg (
      .clk_i  (Clock),
      .rst_ni (Reset_n),
      .ld_i   (ld[g]),
      .d_i    (ld_data[g]),
      .inc_i  (inc[g]),
      .q_o    (reg_q[g])
    );
  end

  assign conflict_d = Mem_valid & WrEn[WE_MDDR];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    rd    = rd_decode(RdSel);
    B_bus = '0;
    if (rd.valid) begin
      B_bus = reg_q[rd.idx];
    end
  end

  assign PC_out   = reg_q[WE_PC];
  assign AR_out   = reg_q[WE_AR];
  assign MDDR_out = reg_q[WE_MDDR];
  assign IR_out   = reg_q[WE_IR];
  assign TR_out   = reg_q[WE_TR];
  assign Conflict = conflict_q;

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have port Clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port WrEn, input, 20, one-hot-or-multi write enables from the write decoder: bit0..13=R1..R14, 14=TOTR, 15=TR, 16=PC, 17=AR, 18=MDDR, 19=IR.
REQ-004 SHALL have port C_bus, input, 16, write data for all WrEn-selected registers.
REQ-005 SHALL have port RdSel, input, 5, read-register code: 1..14=R1..R14, 15=TOTR, 16=TR, 17=PC, 18=AR, 21=MDDR, 22=IR.
REQ-006 SHALL have port B_bus, output, 16, register selected by RdSel.
REQ-007 SHALL have ports PC_inc and AR_inc, input, 1 each, increment requests.
REQ-008 SHALL have ports Mem_valid (input, 1) and Mem_data (input, 16), memory read return loading MDDR.
REQ-009 SHALL have outputs PC_out, AR_out, MDDR_out, IR_out, TR_out, 16 each, direct register values.
REQ-010 SHALL have output Conflict, 1, registered one-cycle pulse flagging an MDDR load collision.

Function
REQ-011 SHALL, on a rising Clock edge with WrEn[i]=1, load C_bus into register i; multiple set bits (broadcast) load all selected registers with the same value in the same cycle.
REQ-012 SHALL hold every register whose enable and update sources are all inactive.
REQ-013 SHALL add 1 to PC when PC_inc=1 and WrEn[16]=0; 0xFFFF wraps to 0x0000, no carry out.
REQ-014 SHALL add 1 to AR when AR_inc=1 and WrEn[17]=0; same 16-bit wrap rule.
REQ-015 SHALL give a bus write priority over an increment on the same register in the same cycle; the increment is dropped, not deferred.
REQ-016 SHALL load Mem_data into MDDR when Mem_valid=1; if WrEn[18]=1 in the same cycle, Mem_data wins and Conflict=1 on the following cycle only.
REQ-017 SHALL drive B_bus combinationally from current register contents (read-before-write: a write in cycle N is visible on B_bus from cycle N+1).
REQ-018 SHALL drive B_bus=0x0000 for RdSel codes 0, 19, 20, 23..31.
REQ-019 SHALL drive PC_out, AR_out, MDDR_out, IR_out, TR_out directly from register contents, zero added latency.
REQ-020 SHALL tolerate WrEn=0 with no side effects; Conflict stays 0 unless REQ-016 triggers.

Reset
REQ-021 SHALL, while Reset_n=0, force R1..R14, TOTR, TR, PC, AR, MDDR, IR to 0x0000 and Conflict to 0, independent of Clock.
REQ-022 SHALL ignore all writes, increments and Mem_valid while Reset_n=0; a write coincident with reset release edge is not required to take effect.
REQ-023 SHALL resume normal operation on the first rising Clock edge after Reset_n deasserts.

Structure
REQ-024 SHALL take data width (16), the register code constants (1..18, 21, 22) and WrEn bit indices from the shared processor package.
REQ-025 SHALL instantiate a sub-module reg16_inc (16-bit register with load, optional increment, async active-low clear) for PC and AR; other registers MAY use the same cell with increment tied low.

Verification
REQ-026 SHALL cover: reset, WrEn[4]=1, C_bus=0x1234 -> next cycle RdSel=5 gives B_bus=0x1234, all other registers 0x0000.
REQ-027 SHALL cover: WrEn=all ones, C_bus=0xA5A5 -> every register and PC_out/AR_out/IR_out/TR_out/MDDR_out = 0xA5A5 next cycle.
REQ-028 SHALL cover: PC=0xFFFF, PC_inc=1 -> PC_out=0x0000; PC=0x0010, PC_inc=1 with WrEn[16]=1, C_bus=0x0200 -> PC_out=0x0200.
REQ-029 SHALL cover: Mem_valid=1, Mem_data=0x00FF with WrEn[18]=1, C_bus=0x1111 -> MDDR_out=0x00FF, Conflict=1 for exactly one cycle.
REQ-030 SHALL cover: RdSel=19, 20, 31 -> B_bus=0x0000; Reset_n pulsed low mid-sequence with AR=0x0042 -> AR_out=0x0000 immediately, before next Clock edge.
